// File: rtl/sim_reset_pkg.sv
// -----------------------------------------------------------------------------
// sim_reset_pkg
// Shared definitions for the simulation reset sequencer:
//   state_t        - 3-bit FSM state encoding exported on the 'state' port
//   release_cycle  - phase count at which a given channel leaves reset
// -----------------------------------------------------------------------------
package sim_reset_pkg;

   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_STAGGER = 3'd1,
      ST_RUN     = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Computed in 64 bits so the range check against 2**CNT_W cannot overflow.
   function automatic longint release_cycle(input int hold_cycles, input int stagger, input int chan);
      return longint'(hold_cycles) + longint'(chan) * longint'(stagger);
   endfunction

endpackage

// File: rtl/sim_reset_chan.sv
// -----------------------------------------------------------------------------
// sim_reset_chan
// One reset domain. Holds its reset output asserted until the shared phase
// counter reaches this channel's release cycle while release is enabled.
// Ports:
//   CLK, RST   - clock and synchronous active-high reset
//   clear      - re-assert the reset on the next edge (wins over release)
//   enable     - release comparison is active (sequencer in STAGGER)
//   phase_cnt  - shared sequencer phase counter
//   rst_out    - registered domain reset, polarity set by ACTIVE_HIGH
// -----------------------------------------------------------------------------
module sim_reset_chan
   import sim_reset_pkg::*;
#(
   parameter int                CNT_W       = 32,
   parameter logic [CNT_W-1:0]  REL_CYCLE   = '0,
   parameter int                ACTIVE_HIGH = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] phase_cnt,
   output logic             rst_out
);

   localparam logic ASSERT_LVL = (ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;

   logic rst_out_r;

   // Release register: asserted on reset/clear, dropped once at the release cycle.
   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         rst_out_r <= ASSERT_LVL;
      end else if (enable && (phase_cnt == REL_CYCLE)) begin
         rst_out_r <= ~ASSERT_LVL;
      end else begin
         rst_out_r <= rst_out_r;
      end
   end

   assign rst_out = rst_out_r;

endmodule

// File: rtl/sim_reset_sequencer.sv
// -----------------------------------------------------------------------------
// sim_reset_sequencer
// Sequences per-domain resets for a simulation top: hold all domains in reset,
// release them one by one with a fixed stagger, run, and on a finish request
// drain for a fixed number of cycles before raising a sticky 'finish'.
// Ports:
//   CLK          - sole clock
//   RST          - synchronous active-high block reset
//   finish_req   - single-cycle request to end simulation
//   soft_reset   - single-cycle request to re-run the reset sequence
//   rst_out      - per-channel domain resets (registered)
//   cycle_count  - saturating cycles since RST deasserted (registered)
//   running      - high while in RUN (registered)
//   finish       - sticky, high in DONE (registered)
//   state        - current FSM state encoding (registered)
// -----------------------------------------------------------------------------
module sim_reset_sequencer
   import sim_reset_pkg::*;
#(
   parameter int NUM_CHAN            = 2,
   parameter int CNT_W               = 32,
   parameter int HOLD_CYCLES         = 20,
   parameter int STAGGER             = 4,
   parameter int DRAIN_CYCLES        = 8,
   parameter int RST_OUT_ACTIVE_HIGH = 0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                finish_req,
   input  logic                soft_reset,
   output logic [NUM_CHAN-1:0] rst_out,
   output logic [CNT_W-1:0]    cycle_count,
   output logic                running,
   output logic                finish,
   output logic [2:0]          state
);

   localparam longint           LAST_REL_L = release_cycle(HOLD_CYCLES, STAGGER, NUM_CHAN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST_REL   = CNT_W'(LAST_REL_L);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   // A zero drain length still spends one cycle in DRAIN.
   localparam logic [CNT_W-1:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? CNT_ONE : CNT_W'(DRAIN_CYCLES);

   // Reject configurations whose last release cycle cannot be represented.
   if (HOLD_CYCLES == 0) begin : g_bad_hold
      $error("sim_reset_sequencer: HOLD_CYCLES must be non-zero");
   end
   if (NUM_CHAN < 1) begin : g_bad_chan
      $error("sim_reset_sequencer: NUM_CHAN must be at least 1");
   end
   if ((CNT_W < 63) && (LAST_REL_L >= (longint'(1) <<< CNT_W))) begin : g_bad_range
      $error("sim_reset_sequencer: last release cycle does not fit in CNT_W");
   end

   state_t           state_r;
   logic [CNT_W-1:0] phase_cnt_r;
   logic [CNT_W-1:0] drain_cnt_r;
   logic [CNT_W-1:0] cycle_count_r;
   logic             finish_pending_r;
   logic             running_r;
   logic             finish_r;

   logic             soft_ok_s;
   logic             illegal_s;
   logic             drain_end_s;
   logic             chan_clear_s;
   logic             chan_enable_s;

   // Classify the current state: where soft_reset is honoured, and illegal encodings.
   always_comb begin
      soft_ok_s = 1'b0;
      illegal_s = 1'b0;
      case (state_r)
         ST_HOLD, ST_STAGGER, ST_RUN: begin
            soft_ok_s = soft_reset;
            illegal_s = 1'b0;
         end
         ST_DRAIN, ST_DONE: begin
            soft_ok_s = 1'b0;
            illegal_s = 1'b0;
         end
         default: begin
            soft_ok_s = 1'b0;
            illegal_s = 1'b1;
         end
      endcase
   end

   // Last DRAIN cycle: the channels re-assert on the same edge that enters DONE.
   assign drain_end_s   = (state_r == ST_DRAIN) && (drain_cnt_r <= CNT_ONE);
   assign chan_clear_s  = soft_ok_s || drain_end_s || (state_r == ST_DONE) || illegal_s;
   assign chan_enable_s = (state_r == ST_STAGGER);

   // Free-running cycle counter, saturating at all-ones; soft_reset leaves it alone.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cycle_count_r <= '0;
      end else if (cycle_count_r != {CNT_W{1'b1}}) begin
         cycle_count_r <= cycle_count_r + CNT_ONE;
      end else begin
         cycle_count_r <= cycle_count_r;
      end
   end

   // Sequencer FSM with its phase/drain counters and registered status outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r          <= ST_HOLD;
         phase_cnt_r      <= '0;
         drain_cnt_r      <= '0;
         finish_pending_r <= 1'b0;
         running_r        <= 1'b0;
         finish_r         <= 1'b0;
      end else begin
         case (state_r)
            ST_HOLD, ST_STAGGER: begin
               if (soft_reset) begin
                  // soft_reset wins; a simultaneous finish_req is dropped.
                  state_r          <= ST_HOLD;
                  phase_cnt_r      <= '0;
                  finish_pending_r <= 1'b0;
               end else begin
                  phase_cnt_r <= phase_cnt_r + CNT_ONE;
                  if (finish_req) begin
                     finish_pending_r <= 1'b1;
                  end else begin
                     finish_pending_r <= finish_pending_r;
                  end
                  if ((state_r == ST_HOLD) && (phase_cnt_r == HOLD_LAST)) begin
                     state_r <= ST_STAGGER;
                  end else if ((state_r == ST_STAGGER) && (phase_cnt_r == LAST_REL)) begin
                     // Same edge that releases the last channel.
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end else begin
                     state_r <= state_r;
                  end
               end
            end
            ST_RUN: begin
               if (soft_reset) begin
                  state_r          <= ST_HOLD;
                  phase_cnt_r      <= '0;
                  finish_pending_r <= 1'b0;
                  running_r        <= 1'b0;
               end else if (finish_req || finish_pending_r) begin
                  state_r          <= ST_DRAIN;
                  drain_cnt_r      <= DRAIN_LOAD;
                  finish_pending_r <= 1'b0;
                  running_r        <= 1'b0;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt_r <= CNT_ONE) begin
                  state_r     <= ST_DONE;
                  drain_cnt_r <= '0;
                  finish_r    <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r - CNT_ONE;
               end
            end
            ST_DONE: begin
               state_r  <= ST_DONE;
               finish_r <= 1'b1;
            end
            default: begin
               state_r          <= ST_HOLD;
               phase_cnt_r      <= '0;
               drain_cnt_r      <= '0;
               finish_pending_r <= 1'b0;
               running_r        <= 1'b0;
               finish_r         <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
      sim_reset_chan #(
         .CNT_W       (CNT_W),
         .REL_CYCLE   (CNT_W'(release_cycle(HOLD_CYCLES, STAGGER, i))),
         .ACTIVE_HIGH (RST_OUT_ACTIVE_HIGH)
      ) u_chan (
         .CLK       (CLK),
         .RST       (RST),
         .clear     (chan_clear_s),
         .enable    (chan_enable_s),
         .phase_cnt (phase_cnt_r),
         .rst_out   (rst_out[i])
      );
   end

   assign cycle_count = cycle_count_r;
   assign running     = running_r;
   assign finish      = finish_r;
   assign state       = state_r;

endmodule

// File: tb/tb_sim_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sim_reset_sequencer
// Scenario bench for sim_reset_sequencer at default parameters. Each scenario
// pushes the expected observations (cycle, field, value) into a queue and then
// steps the clock, popping and comparing entries as their cycle comes up.
// -----------------------------------------------------------------------------
module tb_sim_reset_sequencer;

   localparam int K_RST = 0;
   localparam int K_RUN = 1;
   localparam int K_FIN = 2;
   localparam int K_ST  = 3;
   localparam int BUDGET = 200;

   typedef struct {
      logic [31:0] cyc;
      int          kind;
      logic [31:0] val;
   } exp_t;

   logic        CLK;
   logic        RST;
   logic        finish_req;
   logic        soft_reset;
   logic [1:0]  rst_out;
   logic [31:0] cycle_count;
   logic        running;
   logic        finish;
   logic [2:0]  state;

   int          vectors;
   int          miscompares;
   exp_t        sb[$];
   exp_t        e;
   logic [31:0] cc;

   sim_reset_sequencer dut (
      .CLK         (CLK),
      .RST         (RST),
      .finish_req  (finish_req),
      .soft_reset  (soft_reset),
      .rst_out     (rst_out),
      .cycle_count (cycle_count),
      .running     (running),
      .finish      (finish),
      .state       (state)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         K_RST:   return {30'd0, rst_out};
         K_RUN:   return {31'd0, running};
         K_FIN:   return {31'd0, finish};
         K_ST:    return {29'd0, state};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic string kname(input int kind);
      case (kind)
         K_RST:   return "rst_out";
         K_RUN:   return "running";
         K_FIN:   return "finish";
         K_ST:    return "state";
         default: return "unknown";
      endcase
   endfunction

   function automatic void push(input int cyc, input int kind, input int val);
      exp_t x;
      x.cyc  = 32'(cyc);
      x.kind = kind;
      x.val  = 32'(val);
      sb.push_back(x);
   endfunction

   // Stimulus only: hold RST for three cycles, release at a negedge (cycle_count 0).
   task automatic do_reset();
      RST        = 1'b1;
      finish_req = 1'b0;
      soft_reset = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      cc  = 32'd0;
      sb.delete();
   endtask

   // Expected release sequence after RST, cycles counted from release.
   function automatic void push_release();
      push(20, K_RST, 0);
      push(20, K_ST, 1);
      push(21, K_RST, 1);
      push(24, K_RST, 1);
      push(24, K_RUN, 0);
      push(25, K_RST, 3);
      push(25, K_RUN, 1);
      push(25, K_ST, 2);
   endfunction

   task automatic test_reset();
      RST        = 1'b1;
      finish_req = 1'b1;
      soft_reset = 1'b1;
      repeat (3) @(negedge CLK);
      vectors += 5;
      if (state !== 3'd0) begin miscompares++; $display("FAIL reset state: got %0d want 0", state); end
      if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL reset cycle_count: got %0d want 0", cycle_count); end
      if (rst_out !== 2'b00) begin miscompares++; $display("FAIL reset rst_out: got %b want 00", rst_out); end
      if (running !== 1'b0) begin miscompares++; $display("FAIL reset running: got %b want 0", running); end
      if (finish !== 1'b0) begin miscompares++; $display("FAIL reset finish: got %b want 0", finish); end
      finish_req = 1'b0;
      soft_reset = 1'b0;
   endtask

   task automatic test_release();
      do_reset();
      push_release();
      push(40, K_ST, 2);
      for (int c = 0; c < BUDGET && sb.size() > 0; c++) begin
         while (sb.size() > 0 && sb[0].cyc == cc) begin
            e = sb.pop_front();
            vectors++;
            if (observe(e.kind) !== e.val) begin
               miscompares++;
               $display("FAIL release %s @%0d: got %0h want %0h", kname(e.kind), cc, observe(e.kind), e.val);
            end
         end
         vectors++;
         if (cycle_count !== cc) begin miscompares++; $display("FAIL release cycle_count: got %0d want %0d", cycle_count, cc); end
         @(negedge CLK);
         cc++;
      end
      if (sb.size() > 0) begin vectors++; miscompares++; $display("FAIL release timeout: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_finish_in_run();
      do_reset();
      push(40, K_ST, 2);
      push(41, K_ST, 3);
      push(41, K_RUN, 0);
      push(48, K_ST, 3);
      push(48, K_FIN, 0);
      push(48, K_RST, 3);
      push(49, K_FIN, 1);
      push(49, K_RST, 0);
      push(49, K_ST, 4);
      push(60, K_ST, 4);
      push(60, K_FIN, 1);
      push(60, K_RST, 0);
      for (int c = 0; c < BUDGET && sb.size() > 0; c++) begin
         while (sb.size() > 0 && sb[0].cyc == cc) begin
            e = sb.pop_front();
            vectors++;
            if (observe(e.kind) !== e.val) begin
               miscompares++;
               $display("FAIL finish_run %s @%0d: got %0h want %0h", kname(e.kind), cc, observe(e.kind), e.val);
            end
         end
         // finish_req in RUN, then soft_reset/finish_req in DRAIN and DONE (ignored)
         finish_req = (cc == 32'd40) || (cc == 32'd43) || (cc == 32'd52);
         soft_reset = (cc == 32'd44) || (cc == 32'd55);
         @(negedge CLK);
         cc++;
      end
      finish_req = 1'b0;
      soft_reset = 1'b0;
      if (sb.size() > 0) begin vectors++; miscompares++; $display("FAIL finish_run timeout: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_early_finish();
      do_reset();
      push(24, K_ST, 1);
      push(25, K_ST, 2);
      push(25, K_RUN, 1);
      push(26, K_ST, 3);
      push(33, K_FIN, 0);
      push(34, K_FIN, 1);
      push(34, K_ST, 4);
      for (int c = 0; c < BUDGET && sb.size() > 0; c++) begin
         while (sb.size() > 0 && sb[0].cyc == cc) begin
            e = sb.pop_front();
            vectors++;
            if (observe(e.kind) !== e.val) begin
               miscompares++;
               $display("FAIL early_finish %s @%0d: got %0h want %0h", kname(e.kind), cc, observe(e.kind), e.val);
            end
         end
         finish_req = (cc == 32'd10);
         @(negedge CLK);
         cc++;
      end
      finish_req = 1'b0;
      if (sb.size() > 0) begin vectors++; miscompares++; $display("FAIL early_finish timeout: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_soft_reset();
      do_reset();
      push(50, K_RST, 3);
      push(51, K_RST, 0);
      push(51, K_ST, 0);
      push(51, K_RUN, 0);
      push(71, K_RST, 0);
      push(72, K_RST, 1);
      push(75, K_RST, 1);
      push(76, K_RST, 3);
      push(76, K_RUN, 1);
      for (int c = 0; c < BUDGET && sb.size() > 0; c++) begin
         while (sb.size() > 0 && sb[0].cyc == cc) begin
            e = sb.pop_front();
            vectors++;
            if (observe(e.kind) !== e.val) begin
               miscompares++;
               $display("FAIL soft_reset %s @%0d: got %0h want %0h", kname(e.kind), cc, observe(e.kind), e.val);
            end
         end
         vectors++;
         if (cycle_count !== cc) begin miscompares++; $display("FAIL soft_reset cycle_count: got %0d want %0d", cycle_count, cc); end
         soft_reset = (cc == 32'd50);
         @(negedge CLK);
         cc++;
      end
      soft_reset = 1'b0;
      if (sb.size() > 0) begin vectors++; miscompares++; $display("FAIL soft_reset timeout: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      push(31, K_ST, 0);
      push(31, K_RST, 0);
      push(40, K_FIN, 0);
      push(52, K_RST, 1);
      push(55, K_FIN, 0);
      push(55, K_RUN, 0);
      push(56, K_RUN, 1);
      push(57, K_ST, 2);
      push(70, K_FIN, 0);
      push(70, K_ST, 2);
      for (int c = 0; c < BUDGET && sb.size() > 0; c++) begin
         while (sb.size() > 0 && sb[0].cyc == cc) begin
            e = sb.pop_front();
            vectors++;
            if (observe(e.kind) !== e.val) begin
               miscompares++;
               $display("FAIL simultaneous %s @%0d: got %0h want %0h", kname(e.kind), cc, observe(e.kind), e.val);
            end
         end
         finish_req = (cc == 32'd30);
         soft_reset = (cc == 32'd30);
         @(negedge CLK);
         cc++;
      end
      finish_req = 1'b0;
      soft_reset = 1'b0;
      if (sb.size() > 0) begin vectors++; miscompares++; $display("FAIL simultaneous timeout: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_rst_mid_drain();
      do_reset();
      push(41, K_ST, 3);
      push(45, K_ST, 3);
      push(45, K_RST, 3);
      for (int c = 0; c < BUDGET && sb.size() > 0; c++) begin
         while (sb.size() > 0 && sb[0].cyc == cc) begin
            e = sb.pop_front();
            vectors++;
            if (observe(e.kind) !== e.val) begin
               miscompares++;
               $display("FAIL rst_drain %s @%0d: got %0h want %0h", kname(e.kind), cc, observe(e.kind), e.val);
            end
         end
         if (sb.size() > 0) begin
            finish_req = (cc == 32'd40);
            @(negedge CLK);
            cc++;
         end
      end
      if (sb.size() > 0) begin vectors++; miscompares++; $display("FAIL rst_drain timeout: got %0d pending want 0", sb.size()); end
      // RST together with finish_req and soft_reset: RST must win everything.
      RST        = 1'b1;
      finish_req = 1'b1;
      soft_reset = 1'b1;
      @(negedge CLK);
      RST        = 1'b0;
      finish_req = 1'b0;
      soft_reset = 1'b0;
      vectors += 5;
      if (state !== 3'd0) begin miscompares++; $display("FAIL rst_drain state: got %0d want 0", state); end
      if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL rst_drain cycle_count: got %0d want 0", cycle_count); end
      if (rst_out !== 2'b00) begin miscompares++; $display("FAIL rst_drain rst_out: got %b want 00", rst_out); end
      if (running !== 1'b0) begin miscompares++; $display("FAIL rst_drain running: got %b want 0", running); end
      if (finish !== 1'b0) begin miscompares++; $display("FAIL rst_drain finish: got %b want 0", finish); end
      cc = 32'd0;
      sb.delete();
      push_release();
      push(26, K_ST, 2);
      push(40, K_FIN, 0);
      for (int c = 0; c < BUDGET && sb.size() > 0; c++) begin
         while (sb.size() > 0 && sb[0].cyc == cc) begin
            e = sb.pop_front();
            vectors++;
            if (observe(e.kind) !== e.val) begin
               miscompares++;
               $display("FAIL rst_drain_rerun %s @%0d: got %0h want %0h", kname(e.kind), cc, observe(e.kind), e.val);
            end
         end
         vectors++;
         if (cycle_count !== cc) begin miscompares++; $display("FAIL rst_drain cycle_count: got %0d want %0d", cycle_count, cc); end
         @(negedge CLK);
         cc++;
      end
      if (sb.size() > 0) begin vectors++; miscompares++; $display("FAIL rst_drain_rerun timeout: got %0d pending want 0", sb.size()); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cc          = 32'd0;
      RST         = 1'b1;
      finish_req  = 1'b0;
      soft_reset  = 1'b0;
      test_reset();
      test_release();
      test_finish_in_run();
      test_early_finish();
      test_soft_reset();
      test_simultaneous();
      test_rst_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sim_reset_sequencer.md
SIM_RESET_SEQUENCER -- requirements
Module: sim_reset_sequencer

Interface
REQ-001 Parameter NUM_CHAN, default 2: number of reset domains sequenced.
REQ-002 Parameter CNT_W, default 32: width of cycle and phase counters.
REQ-003 Parameter HOLD_CYCLES, default 20: cycles all channel resets are held after entry to HOLD.
REQ-004 Parameter STAGGER, default 4: cycles between successive channel releases; 0 means all channels release together.
REQ-005 Parameter DRAIN_CYCLES, default 8: cycles between finish acceptance and finish; 0 is treated as 1.
REQ-006 Parameter RST_OUT_ACTIVE_HIGH, default 0: polarity of rst_out; 0 means active-low, the codebase default.
REQ-007 CLK  in  1  sole clock; all logic on posedge CLK.
REQ-008 RST  in  1  synchronous, active-high block reset.
REQ-009 finish_req  in  1  single-cycle request to end simulation, for example from the DPI cycle hook.
REQ-010 soft_reset  in  1  single-cycle request to re-run the reset sequence.
REQ-011 rst_out  out  NUM_CHAN  per-channel domain reset, polarity per RST_OUT_ACTIVE_HIGH.
REQ-012 cycle_count  out  CNT_W  cycles since RST deasserted.
REQ-013 running  out  1  high while the state is RUN.
REQ-014 finish  out  1  sticky level; high in DONE; testbench calls $finish on it.
REQ-015 state  out  3  current FSM state encoding.

Function
REQ-016 The FSM SHALL have states HOLD, STAGGER, RUN, DRAIN and DONE, with a single CNT_W phase counter phase_cnt.
REQ-017 cycle_count SHALL increment every cycle RST is low, and SHALL saturate at all-ones without wrapping.
REQ-018 HOLD SHALL increment phase_cnt and move to STAGGER on the edge where phase_cnt equals HOLD_CYCLES-1.
REQ-019 Channel i SHALL go inactive on the edge where phase_cnt equals HOLD_CYCLES+i*STAGGER, visible the next cycle.
REQ-020 The FSM SHALL enter RUN on the same edge that releases channel NUM_CHAN-1.
REQ-021 With NUM_CHAN=1, the FSM SHALL enter RUN on the edge releasing channel 0.
REQ-022 In RUN, finish_req SHALL move the FSM to DRAIN on the next edge and load the drain counter with max(DRAIN_CYCLES,1).
REQ-023 finish_req in HOLD or STAGGER SHALL set finish_pending; the FSM SHALL enter DRAIN on the edge after RUN is entered.
REQ-024 DRAIN SHALL decrement the drain counter and enter DONE when it reaches 0, so DRAIN lasts exactly max(DRAIN_CYCLES,1) cycles.
REQ-025 DONE SHALL be absorbing until RST, with finish high and all rst_out asserted.
REQ-026 soft_reset in HOLD, STAGGER or RUN SHALL, on the next edge, assert all rst_out, clear phase_cnt and finish_pending, and enter HOLD; it SHALL NOT clear cycle_count.
REQ-027 soft_reset SHALL be ignored in DRAIN and DONE.
REQ-028 When soft_reset and finish_req are simultaneous, soft_reset SHALL win and finish_req SHALL be dropped.
REQ-029 finish_req SHALL be ignored in DRAIN and DONE.
REQ-030 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-031 Elaboration SHALL fail if HOLD_CYCLES+(NUM_CHAN-1)*STAGGER >= 2**CNT_W or HOLD_CYCLES = 0.

Reset
REQ-032 RST high SHALL force, on the next edge: state HOLD, phase_cnt 0, cycle_count 0, drain counter 0, finish_pending 0, all rst_out asserted, running 0, finish 0.
REQ-033 RST SHALL override finish_req and soft_reset in every state, including mid-DRAIN and DONE.

Structure
REQ-034 Package sim_reset_pkg SHALL hold the state typedef (3-bit enum: HOLD=0, STAGGER=1, RUN=2, DRAIN=3, DONE=4) and a release-cycle constant function.
REQ-035 Sub-module sim_reset_chan SHALL be instantiated once per channel; it holds the release register and compares phase_cnt against its parameterised release cycle.
REQ-036 The target size is 120-400 lines of RTL in total.

Verification (default parameters)
REQ-037 RST high for 3 cycles, then idle -> rst_out[0] goes 1 at cycle_count 21, rst_out[1] goes 1 and running goes 1 at cycle_count 25.
REQ-038 finish_req pulse at cycle_count 40 -> state DRAIN at 41, finish high at 49, all rst_out low at 49.
REQ-039 finish_req pulse at cycle_count 10 -> RUN at 25, DRAIN at 26, finish high at 34.
REQ-040 soft_reset at cycle_count 50 -> all rst_out low at 51, rst_out[0] high at 72, rst_out[1] high and running high at 76, cycle_count unbroken.
REQ-041 soft_reset and finish_req together at cycle_count 30 -> HOLD at 31, finish never rises before the next RUN.
REQ-042 RST pulsed at cycle_count 45, mid-DRAIN -> all reset values next cycle, cycle_count 0, and the sequence repeats as in REQ-037.
